floor_scheduler: RTL and testbench
==================================

FLOOR_SCHEDULER -- requirements
Module: floor_scheduler

Interface
REQ-001 SHALL have parameter BUTTONS_WIDTH, default 8, number of floors (floor 0 .. BUTTONS_WIDTH-1).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 16, clock cycles to move one floor.
REQ-003 SHALL have parameter DOOR_CYCLES, default 32, clock cycles the door stays open.
REQ-004 SHALL have port clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port an_reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port emergency_stop  in  1  level; high halts the cabin.
REQ-007 SHALL have port active_in_levels  in  [BUTTONS_WIDTH-1:0]  pending cabin requests.
REQ-008 SHALL have port active_out_up_levels  in  [BUTTONS_WIDTH-2:0]  pending hall-up calls.
REQ-009 SHALL have port active_out_down_levels  in  [BUTTONS_WIDTH-1:1]  pending hall-down calls.
REQ-010 SHALL have port inactivate_in_levels  out  [BUTTONS_WIDTH-1:0]  one-cycle clear pulses, cabin.
REQ-011 SHALL have port inactivate_out_up_levels  out  [BUTTONS_WIDTH-2:0]  one-cycle clear pulses, hall-up.
REQ-012 SHALL have port inactivate_out_down_levels  out  [BUTTONS_WIDTH-1:1]  one-cycle clear pulses, hall-down.
REQ-013 SHALL have port buttons_block  out  1  high ignores new button presses.
REQ-014 SHALL have port current_floor  out  [$clog2(BUTTONS_WIDTH)-1:0]  cabin floor index.
REQ-015 SHALL have ports motor_up, motor_down, door_open  out  1 each  actuator commands.

Function
REQ-016 SHALL register all outputs; no combinational input-to-output path.
REQ-017 SHALL implement FSM states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, HALT, plus a dir register {NONE, UP, DOWN}.
REQ-018 Terms: req[f] = in[f]|up[f]|down[f]; above(f) = any req at floor >f; below(f) = any req at floor <f; out-of-range up/down bits read as 0.
REQ-019 IDLE: req[cur] -> DOOR_OPEN, clear in/up/down at cur; else dir=UP and above -> MOVE_UP; dir=DOWN and below -> MOVE_DOWN; else above -> MOVE_UP; else below -> MOVE_DOWN; else stay, dir=NONE.
REQ-020 MOVE_x: motor_up or motor_down high; counter runs TRAVEL_CYCLES cycles, then current_floor +/-1 and the stop test runs on the new floor f in the same cycle.
REQ-021 Stop test UP: stop if in[f] | up[f] | (!above(f) & down[f]) | f==top; clear in[f], up[f], and down[f] when !above(f).
REQ-022 Stop test DOWN: mirror of REQ-021, f==0 is the bottom stop; clear in[f], down[f], and up[f] when !below(f).
REQ-023 If the test does not stop and no request lies ahead (requests withdrawn), SHALL go to IDLE with motor off and door closed, no clear pulses.
REQ-024 Clear pulses SHALL be high exactly one cycle, in the cycle DOOR_OPEN is entered, only for bits that were active.
REQ-025 DOOR_OPEN: door_open high, motors low, counter runs DOOR_CYCLES cycles, then IDLE with dir kept.
REQ-026 A new req[cur] arriving in DOOR_OPEN SHALL pulse its clear and restart the door counter.
REQ-027 emergency_stop high in any state -> HALT next cycle: motors low, door_open low, buttons_block high, move counter cleared, current_floor unchanged.
REQ-028 HALT exits to IDLE with dir=NONE on the first cycle emergency_stop is low; a partial floor travel is restarted from zero.
REQ-029 buttons_block SHALL be low in all states except HALT.
REQ-030 Counter SHALL be sized for max(TRAVEL_CYCLES, DOOR_CYCLES) and never wrap.

Reset
REQ-031 an_reset low SHALL immediately force IDLE, dir=NONE, current_floor=0, counter=0.
REQ-032 During reset all outputs SHALL be 0. Reset mid-move or mid-door SHALL abandon the operation with no clear pulses emitted.

Structure
REQ-033 Shared package elevator_pkg SHALL hold the state and dir enums and the default timing constants.
REQ-034 Combinational request evaluation (above, below, stop, clear masks) SHALL be the single sub-module floor_req_eval.

Verification (BUTTONS_WIDTH=8, TRAVEL_CYCLES=4, DOOR_CYCLES=8)
REQ-035 At floor 0, in[3] set -> motor_up for 12 cycles, current_floor=3, one-cycle inactivate_in_levels[3], door_open for 8 cycles, then IDLE.
REQ-036 Moving up from 0 with up[2] and down[5] pending -> stops at 2 clearing up[2], then at 5 clearing down[5].
REQ-037 Moving up from 0 with down[4] and in[6] pending -> passes 4, stops at 6, reverses, stops at 4.
REQ-038 in[2] withdrawn at cycle 2 of travel from floor 1 -> arrives at 2, no door, no pulse, IDLE.
REQ-039 emergency_stop high mid-travel 0->1 -> HALT, buttons_block=1, floor 0; release -> full 4-cycle travel resumes.
REQ-040 an_reset asserted during DOOR_OPEN -> all outputs 0 immediately, floor 0, no pulses after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and timing defaults for the floor scheduler.
//   state_e   : cabin controller states
//   dir_e     : remembered travel direction
//   cnt_width : width of the shared travel/door down-counter
package elevator_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR_OPEN,
      HALT
   } state_e;

   typedef enum logic [1:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN
   } dir_e;

   localparam int DEFAULT_BUTTONS_WIDTH = 8;
   localparam int DEFAULT_TRAVEL_CYCLES = 16;
   localparam int DEFAULT_DOOR_CYCLES   = 32;

   // The counter is loaded with (cycles - 1) and counts down to zero, so it
   // only has to hold the larger of the two loads.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/floor_scheduler_if.sv
// Request/actuator bundle between the button logic and the floor scheduler.
//   master : button panel / testbench side (drives requests, sees commands)
//   slave  : scheduler side (sees requests, drives clears and actuators)
interface floor_scheduler_if #(
   parameter int BUTTONS_WIDTH = 8
);
   localparam int FW = (BUTTONS_WIDTH > 1) ? $clog2(BUTTONS_WIDTH) : 1;

   logic                     emergency_stop;
   logic [BUTTONS_WIDTH-1:0] active_in_levels;
   logic [BUTTONS_WIDTH-2:0] active_out_up_levels;
   logic [BUTTONS_WIDTH-1:1] active_out_down_levels;

   logic [BUTTONS_WIDTH-1:0] inactivate_in_levels;
   logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels;
   logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels;
   logic                     buttons_block;
   logic [FW-1:0]            current_floor;
   logic                     motor_up;
   logic                     motor_down;
   logic                     door_open;

   modport master (
      output emergency_stop, active_in_levels, active_out_up_levels, active_out_down_levels,
      input  inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
      input  buttons_block, current_floor, motor_up, motor_down, door_open
   );

   modport slave (
      input  emergency_stop, active_in_levels, active_out_up_levels, active_out_down_levels,
      output inactivate_in_levels, inactivate_out_up_levels, inactivate_out_down_levels,
      output buttons_block, current_floor, motor_up, motor_down, door_open
   );

endinterface

// File: rtl/floor_req_eval.sv
// Combinational request evaluation for one floor.
//   floor_i  : floor being evaluated
//   mode_i   : DIR_UP / DIR_DOWN apply the directional stop test,
//              DIR_NONE treats any request at the floor as a stop
//   in_i/up_i/dn_i : pending cabin, hall-up, hall-down requests
//   above_o/below_o : any request strictly above / below floor_i
//   stop_o   : cabin should stop at floor_i
//   clr_*_o  : active bits at floor_i that a stop here would serve
module floor_req_eval
   import elevator_pkg::*;
#(
   parameter int BUTTONS_WIDTH = 8,
   parameter int FW            = 3
) (
   input  logic [FW-1:0]            floor_i,
   input  dir_e                     mode_i,
   input  logic [BUTTONS_WIDTH-1:0] in_i,
   input  logic [BUTTONS_WIDTH-2:0] up_i,
   input  logic [BUTTONS_WIDTH-1:1] dn_i,
   output logic                     above_o,
   output logic                     below_o,
   output logic                     stop_o,
   output logic [BUTTONS_WIDTH-1:0] clr_in_o,
   output logic [BUTTONS_WIDTH-2:0] clr_up_o,
   output logic [BUTTONS_WIDTH-1:1] clr_dn_o
);

   logic [BUTTONS_WIDTH-1:0] up_full;
   logic [BUTTONS_WIDTH-1:0] dn_full;
   logic [BUTTONS_WIDTH-1:0] req_full;
   logic [BUTTONS_WIDTH-1:0] onehot;
   logic                     here_in;
   logic                     here_up;
   logic                     here_dn;
   logic                     is_top;
   logic                     is_bot;
   logic                     take_up;
   logic                     take_dn;

   always_comb begin
      // no hall-up call exists at the top floor, no hall-down at floor 0
      up_full  = {1'b0, up_i};
      dn_full  = {dn_i, 1'b0};
      req_full = in_i | up_full | dn_full;

      above_o = 1'b0;
      below_o = 1'b0;
      for (int i = 0; i < BUTTONS_WIDTH; i++) begin
         if (i > int'(floor_i)) above_o = above_o | req_full[i];
         if (i < int'(floor_i)) below_o = below_o | req_full[i];
      end

      onehot          = '0;
      onehot[floor_i] = 1'b1;

      here_in = in_i[floor_i];
      here_up = up_full[floor_i];
      here_dn = dn_full[floor_i];
      is_top  = (floor_i == FW'(BUTTONS_WIDTH - 1));
      is_bot  = (floor_i == '0);

      // an opposite-direction hall call is only served when nothing lies ahead
      take_up = (mode_i != DIR_DOWN) | ~below_o;
      take_dn = (mode_i != DIR_UP)   | ~above_o;

      case (mode_i)
         DIR_UP:   stop_o = here_in | here_up | (~above_o & here_dn) | is_top;
         DIR_DOWN: stop_o = here_in | here_dn | (~below_o & here_up) | is_bot;
         default:  stop_o = here_in | here_up | here_dn;
      endcase

      clr_in_o = in_i & onehot;
      clr_up_o = take_up ? (up_i & onehot[BUTTONS_WIDTH-2:0]) : '0;
      clr_dn_o = take_dn ? (dn_i & onehot[BUTTONS_WIDTH-1:1]) : '0;
   end

endmodule

// File: rtl/floor_scheduler.sv
// Single-cabin floor scheduler: picks travel direction from pending calls,
// times floor-to-floor travel and door dwell, and pulses clears for served
// calls. All outputs are registered.
//   clock, an_reset : system clock, async active-low reset
//   bus (slave)     : requests + emergency_stop in; clears, buttons_block,
//                     current_floor, motor_up/motor_down, door_open out
//
// state     | meaning
// IDLE      | cabin parked, choosing next action
// MOVE_UP   | motor_up on, counting one floor of travel
// MOVE_DOWN | motor_down on, counting one floor of travel
// DOOR_OPEN | door open, counting dwell; new local calls restart dwell
// HALT      | emergency stop held, everything off, buttons blocked
module floor_scheduler
   import elevator_pkg::*;
#(
   parameter int BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH,
   parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
   parameter int DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
   input  logic         clock,
   input  logic         an_reset,
   floor_scheduler_if.slave bus
);

   localparam int FW = (BUTTONS_WIDTH > 1) ? $clog2(BUTTONS_WIDTH) : 1;
   localparam int CW = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
   localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

   state_e                   state_q;
   dir_e                     dir_q;
   logic [FW-1:0]            floor_q;
   logic [CW-1:0]            cnt_q;
   logic                     motor_up_q;
   logic                     motor_down_q;
   logic                     door_q;
   logic                     block_q;
   logic [BUTTONS_WIDTH-1:0] clr_in_q;
   logic [BUTTONS_WIDTH-2:0] clr_up_q;
   logic [BUTTONS_WIDTH-1:1] clr_dn_q;

   logic [FW-1:0]            eval_floor_d;
   dir_e                     eval_mode_d;
   logic                     ev_above;
   logic                     ev_below;
   logic                     ev_stop;
   logic [BUTTONS_WIDTH-1:0] ev_clr_in;
   logic [BUTTONS_WIDTH-2:0] ev_clr_up;
   logic [BUTTONS_WIDTH-1:1] ev_clr_dn;
   logic [BUTTONS_WIDTH-1:0] new_in_d;
   logic [BUTTONS_WIDTH-2:0] new_up_d;
   logic [BUTTONS_WIDTH-1:1] new_dn_d;
   logic                     door_new_d;

   // While moving, evaluate the floor the cabin is about to reach so the
   // stop decision lands in the same cycle as the floor update.
   always_comb begin
      eval_floor_d = floor_q;
      eval_mode_d  = DIR_NONE;
      case (state_q)
         MOVE_UP: begin
            eval_floor_d = floor_q + FW'(1);
            eval_mode_d  = DIR_UP;
         end
         MOVE_DOWN: begin
            eval_floor_d = floor_q - FW'(1);
            eval_mode_d  = DIR_DOWN;
         end
         DOOR_OPEN: eval_mode_d = dir_q;
         default: ;
      endcase

      // a bit still high in the cycle its clear is pulsing is not a new press
      new_in_d   = ev_clr_in & ~clr_in_q;
      new_up_d   = ev_clr_up & ~clr_up_q;
      new_dn_d   = ev_clr_dn & ~clr_dn_q;
      door_new_d = |{new_in_d, new_up_d, new_dn_d};
   end

   floor_req_eval #(
      .BUTTONS_WIDTH (BUTTONS_WIDTH),
      .FW            (FW)
   ) u_eval (
      .floor_i  (eval_floor_d),
      .mode_i   (eval_mode_d),
      .in_i     (bus.active_in_levels),
      .up_i     (bus.active_out_up_levels),
      .dn_i     (bus.active_out_down_levels),
      .above_o  (ev_above),
      .below_o  (ev_below),
      .stop_o   (ev_stop),
      .clr_in_o (ev_clr_in),
      .clr_up_o (ev_clr_up),
      .clr_dn_o (ev_clr_dn)
   );

   always_ff @(posedge clock or negedge an_reset) begin
      if (!an_reset) begin
         state_q      <= IDLE;
         dir_q        <= DIR_NONE;
         floor_q      <= '0;
         cnt_q        <= '0;
         motor_up_q   <= 1'b0;
         motor_down_q <= 1'b0;
         door_q       <= 1'b0;
         block_q      <= 1'b0;
         clr_in_q     <= '0;
         clr_up_q     <= '0;
         clr_dn_q     <= '0;
      end else begin
         clr_in_q <= '0;
         clr_up_q <= '0;
         clr_dn_q <= '0;

         if (bus.emergency_stop) begin
            state_q      <= HALT;
            cnt_q        <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_q       <= 1'b0;
            block_q      <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (ev_stop) begin
                     state_q  <= DOOR_OPEN;
                     door_q   <= 1'b1;
                     cnt_q    <= DOOR_LOAD;
                     clr_in_q <= ev_clr_in;
                     clr_up_q <= ev_clr_up;
                     clr_dn_q <= ev_clr_dn;
                  end else if ((ev_above && dir_q != DIR_DOWN) || (ev_above && !ev_below)) begin
                     state_q    <= MOVE_UP;
                     dir_q      <= DIR_UP;
                     motor_up_q <= 1'b1;
                     cnt_q      <= TRAVEL_LOAD;
                  end else if (ev_below) begin
                     state_q      <= MOVE_DOWN;
                     dir_q        <= DIR_DOWN;
                     motor_down_q <= 1'b1;
                     cnt_q        <= TRAVEL_LOAD;
                  end else begin
                     dir_q <= DIR_NONE;
                  end
               end

               MOVE_UP, MOVE_DOWN: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CW'(1);
                  end else begin
                     floor_q <= eval_floor_d;
                     if (ev_stop) begin
                        state_q      <= DOOR_OPEN;
                        motor_up_q   <= 1'b0;
                        motor_down_q <= 1'b0;
                        door_q       <= 1'b1;
                        cnt_q        <= DOOR_LOAD;
                        clr_in_q     <= ev_clr_in;
                        clr_up_q     <= ev_clr_up;
                        clr_dn_q     <= ev_clr_dn;
                     end else if ((state_q == MOVE_UP) ? ev_above : ev_below) begin
                        cnt_q <= TRAVEL_LOAD;
                     end else begin
                        // calls withdrawn mid-travel: park without opening
                        state_q      <= IDLE;
                        motor_up_q   <= 1'b0;
                        motor_down_q <= 1'b0;
                     end
                  end
               end

               DOOR_OPEN: begin
                  if (door_new_d) begin
                     clr_in_q <= new_in_d;
                     clr_up_q <= new_up_d;
                     clr_dn_q <= new_dn_d;
                     cnt_q    <= DOOR_LOAD;
                  end else if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CW'(1);
                  end else begin
                     state_q <= IDLE;
                     door_q  <= 1'b0;
                  end
               end

               HALT: begin
                  state_q <= IDLE;
                  dir_q   <= DIR_NONE;
                  block_q <= 1'b0;
               end

               default: begin
                  state_q <= IDLE;
                  dir_q   <= DIR_NONE;
               end
            endcase
         end
      end
   end

   assign bus.inactivate_in_levels       = clr_in_q;
   assign bus.inactivate_out_up_levels   = clr_up_q;
   assign bus.inactivate_out_down_levels = clr_dn_q;
   assign bus.buttons_block              = block_q;
   assign bus.current_floor              = floor_q;
   assign bus.motor_up                   = motor_up_q;
   assign bus.motor_down                 = motor_down_q;
   assign bus.door_open                  = door_q;

endmodule

// File: tb/tb_floor_scheduler.sv
// Directed bench for floor_scheduler with 8 floors, 4-cycle travel and
// 8-cycle door dwell. Button latches are modelled in tick(): a request bit
// drops in the cycle its clear pulse is seen.
module tb_floor_scheduler;

   logic clock;
   logic an_reset;

   int vectors;
   int errs;
   int up_cnt;
   int dn_cnt;
   int door_cnt;
   int pulse_cycles;
   logic [7:0] acc_in;
   logic [6:0] acc_up;
   logic [6:0] acc_dn;

   floor_scheduler_if #(.BUTTONS_WIDTH(8)) bus ();

   floor_scheduler #(
      .BUTTONS_WIDTH (8),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (8)
   ) dut (
      .clock    (clock),
      .an_reset (an_reset),
      .bus      (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {3'b000, bus.motor_up, bus.motor_down, bus.door_open, bus.buttons_block,
              bus.current_floor, bus.inactivate_in_levels, bus.inactivate_out_up_levels,
              bus.inactivate_out_down_levels};
   endfunction

   task automatic clr_acc();
      up_cnt       = 0;
      dn_cnt       = 0;
      door_cnt     = 0;
      pulse_cycles = 0;
      acc_in       = '0;
      acc_up       = '0;
      acc_dn       = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (bus.motor_up)   up_cnt++;
      if (bus.motor_down) dn_cnt++;
      if (bus.door_open)  door_cnt++;
      if (|{bus.inactivate_in_levels, bus.inactivate_out_up_levels,
            bus.inactivate_out_down_levels}) pulse_cycles++;
      acc_in = acc_in | bus.inactivate_in_levels;
      acc_up = acc_up | bus.inactivate_out_up_levels;
      acc_dn = acc_dn | bus.inactivate_out_down_levels;
      bus.active_in_levels       = bus.active_in_levels & ~bus.inactivate_in_levels;
      bus.active_out_up_levels   = bus.active_out_up_levels & ~bus.inactivate_out_up_levels;
      bus.active_out_down_levels = bus.active_out_down_levels & ~bus.inactivate_out_down_levels;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      an_reset                   = 1'b0;
      bus.emergency_stop         = 1'b0;
      bus.active_in_levels       = '0;
      bus.active_out_up_levels   = '0;
      bus.active_out_down_levels = '0;
      run(2);
      an_reset = 1'b1;
      clr_acc();
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      clr_acc();

      // reset state
      do_reset();
      chk("reset_outputs", all_outs(), 32'h0);

      // cabin call from floor 0 to 3
      bus.active_in_levels = 8'h08;
      tick();
      chk("c3_motor_start", bus.motor_up, 1'b1);
      run(11);
      chk("c3_floor_mid", bus.current_floor, 3'd2);
      tick();
      chk("c3_arrive_floor", bus.current_floor, 3'd3);
      chk("c3_arrive_door", {bus.motor_up, bus.door_open}, 2'b01);
      chk("c3_clear_pulse", bus.inactivate_in_levels, 8'h08);
      run(8);
      chk("c3_motor_cycles", up_cnt, 12);
      chk("c3_door_cycles", door_cnt, 8);
      chk("c3_pulse_once", pulse_cycles, 1);
      chk("c3_door_closed", bus.door_open, 1'b0);

      // hall-up 2 and hall-down 5 while heading up
      do_reset();
      bus.active_out_up_levels   = 7'b0000100;
      bus.active_out_down_levels = 7'b0010000;
      run(9);
      chk("hall_stop2_floor", bus.current_floor, 3'd2);
      chk("hall_stop2_clear", bus.inactivate_out_up_levels, 7'b0000100);
      chk("hall_stop2_noclr_dn", bus.inactivate_out_down_levels, 7'b0000000);
      run(21);
      chk("hall_stop5_floor", bus.current_floor, 3'd5);
      chk("hall_stop5_door", bus.door_open, 1'b1);
      chk("hall_stop5_clear", bus.inactivate_out_down_levels, 7'b0010000);

      // down-4 passed on the way up to cabin 6, served on the way back
      do_reset();
      bus.active_out_down_levels = 7'b0001000;
      bus.active_in_levels       = 8'h40;
      run(17);
      chk("rev_pass4_floor", bus.current_floor, 3'd4);
      chk("rev_pass4_moving", bus.motor_up, 1'b1);
      chk("rev_pass4_nopulse", pulse_cycles, 0);
      run(8);
      chk("rev_stop6_floor", bus.current_floor, 3'd6);
      chk("rev_stop6_clear", bus.inactivate_in_levels, 8'h40);
      run(9);
      chk("rev_turn_down", {bus.motor_up, bus.motor_down}, 2'b01);
      run(8);
      chk("rev_stop4_floor", bus.current_floor, 3'd4);
      chk("rev_stop4_door", bus.door_open, 1'b1);
      chk("rev_stop4_clear", bus.inactivate_out_down_levels, 7'b0001000);

      // withdrawn call during travel 1 -> 2
      do_reset();
      bus.active_in_levels = 8'h02;
      run(14);
      chk("wd_at_floor1", {bus.current_floor, bus.door_open, bus.motor_up}, {3'd1, 2'b00});
      bus.active_in_levels = 8'h04;
      tick();
      chk("wd_depart", bus.motor_up, 1'b1);
      tick();
      bus.active_in_levels = 8'h00;
      clr_acc();
      run(3);
      chk("wd_arrive_floor", bus.current_floor, 3'd2);
      chk("wd_motor_off", bus.motor_up, 1'b0);
      run(4);
      chk("wd_motor_cycles", up_cnt, 2);
      chk("wd_no_door", door_cnt, 0);
      chk("wd_no_pulse", pulse_cycles, 0);

      // emergency stop mid-travel 0 -> 1
      do_reset();
      bus.active_in_levels = 8'h02;
      run(2);
      bus.emergency_stop = 1'b1;
      tick();
      chk("es_halt", {bus.buttons_block, bus.motor_up, bus.door_open}, 3'b100);
      chk("es_floor", bus.current_floor, 3'd0);
      run(3);
      chk("es_held", {bus.buttons_block, bus.motor_up}, 2'b10);
      bus.emergency_stop = 1'b0;
      clr_acc();
      tick();
      chk("es_release_block", bus.buttons_block, 1'b0);
      run(4);
      chk("es_full_travel", up_cnt, 4);
      chk("es_not_arrived", bus.current_floor, 3'd0);
      tick();
      chk("es_arrive", {bus.current_floor, bus.door_open}, {3'd1, 1'b1});

      // door dwell restarted by a fresh call at the current floor
      do_reset();
      bus.active_in_levels = 8'h01;
      tick();
      chk("dr_open", {bus.door_open, bus.inactivate_in_levels}, {1'b1, 8'h01});
      run(3);
      bus.active_in_levels = 8'h01;
      tick();
      chk("dr_repulse", bus.inactivate_in_levels, 8'h01);
      run(7);
      chk("dr_still_open", bus.door_open, 1'b1);
      tick();
      chk("dr_closed", bus.door_open, 1'b0);

      // reset asserted while the door is open
      do_reset();
      bus.active_in_levels = 8'h04;
      run(10);
      chk("rd_door_before", {bus.current_floor, bus.door_open}, {3'd2, 1'b1});
      an_reset = 1'b0;
      #1;
      chk("rd_outputs_zero", all_outs(), 32'h0);
      run(2);
      an_reset = 1'b1;
      clr_acc();
      run(10);
      chk("rd_no_pulse", pulse_cycles, 0);
      chk("rd_no_door", door_cnt, 0);
      chk("rd_floor", bus.current_floor, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
